// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter over four valid/ready requesters feeding a one-entry output register.
// The winner's data is steered through a 4:1 select path; out_sel reports the winning index.
module rr_mux_arbiter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   en,
    input  logic [3:0]   req_valid,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    output logic [3:0]   req_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_sel
);

    logic [1:0]   ptr_q, ptr_d;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic [1:0]   out_sel_q, out_sel_d;

    logic [3:0]   eligible;
    logic         can_load;
    logic         grant_vld;
    logic [1:0]   grant_idx;
    logic [1:0]   scan_idx;
    logic [W-1:0] grant_data;
    logic         grant_fire;

    assign eligible = req_valid & en;
    assign can_load = !out_valid_q || out_ready;

    // Scan from ptr upward with 2-bit wraparound; first eligible index wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = ptr_q;
        scan_idx  = ptr_q;
        for (int k = 0; k < 4; k++) begin
            scan_idx = ptr_q + 2'(k);
            if (!grant_vld && eligible[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    // Only the selected leg reaches the output, so X on other requesters cannot leak.
    always_comb begin
        grant_data = '0;
        unique case (grant_idx)
            2'd0: grant_data = d0;
            2'd1: grant_data = d1;
            2'd2: grant_data = d2;
            2'd3: grant_data = d3;
            default: grant_data = '0;
        endcase
    end

    assign grant_fire = rst_n && can_load && grant_vld;

    always_comb begin
        req_ready = 4'b0000;
        if (grant_fire) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (can_load) begin
            if (grant_vld) begin
                out_valid_d = 1'b1;
                out_data_d  = grant_data;
                out_sel_d   = grant_idx;
                ptr_d       = grant_idx + 2'd1;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q       <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= 2'd0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter and output register wrapped around a 4:1, 4-bit-wide selection datapath. It shares one downstream valid/ready channel between four requesters. Each cycle it picks at most one requester, steers that requester's data through the select path into a one-entry output register, and reports which source won. It sits in front of any consumer that needs fair, one-beat-at-a-time access to the four data sources.

## Interface
Parameters:
- W, default 4, data width of every requester and of the output.

Ports (clock and reset first):
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- en  input  4  per-requester enable mask. A requester with its en bit at 0 is never granted.
- req_valid  input  4  bit i: requester i presents data.
- d0, d1, d2, d3  input  W each  requester data.
- req_ready  output  4  bit i: requester i's beat is accepted this cycle. One-hot or zero.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts the beat this cycle.
- out_data  output  W  registered data of the beat.
- out_sel  output  2  index of the requester that produced out_data.

## Operation
- State:
  - ptr[1:0]: highest-priority requester for the next grant.
  - Output register: out_valid, out_data, out_sel.
- Eligible set: e = req_valid & en.
- can_load = !out_valid || out_ready. The slot is empty, or it is being drained this cycle.
- Grant selection:
  - g is the first index i with e[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - If e == 0, there is no grant.
- req_ready[g] = can_load && (e != 0); all other bits are 0.
  - req_ready is combinational from req_valid, en, ptr, out_valid and out_ready.
  - req_ready must never depend on a requester's own data.
- On a grant (req_ready[g]=1):
  - out_data <= dg, where dg is chosen exactly as a 4:1 mux with sel=g (00→d0, 01→d1, 10→d2, 11→d3).
  - out_sel <= g, out_valid <= 1, ptr <= g+1 (wraps 3→0).
- No grant while can_load is true: out_valid <= 0. out_data and out_sel hold their last values (don't-care when invalid).
- can_load false (out_valid=1, out_ready=0): out_valid, out_data, out_sel and ptr all hold. req_ready = 0.
- ptr changes only on a grant. Masked or idle requesters never advance it.
- en changes take effect in the same cycle. Clearing en[i] never corrupts a beat already in the output register.
- A requester must hold req_valid and its data until req_ready is seen. The arbiter makes no guarantee otherwise.
- X on a non-granted requester's data must not propagate to out_data.

## Timing
- Reset (rst_n=0 at a rising edge):
  - out_valid=0, out_data=0, out_sel=0, ptr=0.
  - req_ready is 0 throughout the reset cycle.
  - Reset mid-transfer discards the held beat.
- Latency: a beat accepted at edge k is visible on out_data/out_valid right after edge k.
- Throughput: one beat per cycle when out_ready is held at 1. Back-to-back grants are allowed in consecutive cycles.
- Simultaneous drain and load: the old beat leaves and the new beat loads on the same edge, with no bubble.
- Fairness: with all four requesters eligible continuously and out_ready=1, grants cycle 0,1,2,3,0,… Every eligible requester is served within 4 grants.

## Test plan
- Reset then idle: rst_n=0 for 2 cycles, then req_valid=0 → out_valid=0, out_data=0, out_sel=0, req_ready=0 every cycle.
- Full rotation: en=4'hF, req_valid=4'hF, d0..d3 = a,b,c,d, out_ready=1 → out_sel sequence 0,1,2,3,0 and out_data sequence a,b,c,d,a on consecutive cycles, with no gaps.
- Backpressure: one beat from d2=7 loaded, then out_ready=0 for 3 cycles while req_valid=4'hF → out_data=7 and out_sel=2 held, req_ready=0, ptr unchanged. On out_ready=1, the next grant goes to requester 3.
- Pointer skip and wrap: ptr=3, req_valid=4'b0110 → grant requester 1 (out_sel=1), then requester 2 next cycle, then ptr=3.
- Masking with X data: en=4'b1011, req_valid=4'hF, d2='x → requester 2 is never granted. Grants cycle 0,1,3. out_data never shows X.
- Reset mid-stream: rst_n=0 while out_valid=1 and out_ready=0 → next cycle out_valid=0 and ptr=0. After release with req_valid=4'hF, the first grant is requester 0.
